// File: rtl/mod_counter_p_pkg.sv
// Purpose     : shared constants and helpers for the mod_counter_p slice.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
// Contents    : DIR_UP/DIR_DOWN direction encodings, clamp() used on load.
package mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Widest count supported by clamp(); callers size-cast in and out.
    localparam int CLAMP_W = 32;

    // min(val, modv): a loaded value never lands outside 0..modulus.
    function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] val,
                                                 input logic [CLAMP_W-1:0] modv);
        return (val > modv) ? modv : val;
    endfunction

endpackage

// File: rtl/mod_counter_p_if.sv
// Purpose     : control/status bundle of the modulo counter.
// Latency     : n/a (wiring only).
// Backpressure: none; the counter accepts control every cycle.
// Signals     : en/dir/clr/load/load_val/modulus driven by master,
//               count/tc/wrap driven by slave (the counter).
interface mod_counter_p_if #(
    parameter int WIDTH = 2
);
    logic             en;
    logic             dir;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] modulus;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             wrap;

    modport master (
        output en, dir, clr, load, load_val, modulus,
        input  count, tc, wrap
    );

    modport slave (
        input  en, dir, clr, load, load_val, modulus,
        output count, tc, wrap
    );
endinterface

// File: rtl/mod_counter_p_tick_prescaler.sv
// Purpose     : divides enabled cycles down to one tick every PRESCALE enabled cycles.
// Latency     : tick is combinational from en and the registered phase.
// Backpressure: none; en=0 freezes the phase, sync_clr restarts it at 0.
// Ports       : clk, rst_n (async active-low), en, sync_clr -> tick.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);
    localparam int PS_W = $clog2(PRESCALE) + 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] ps_q;

    assign tick = en & (ps_q == PS_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else if (sync_clr) begin
            ps_q <= '0;
        end else if (en) begin
            ps_q <= tick ? '0 : ps_q + PS_W'(1);
        end
    end
endmodule

// File: rtl/mod_counter_p.sv
// Purpose     : programmable modulo up/down counter (range 0..modulus) with prescaler.
// Latency     : count/wrap registered (1 cycle); tc combinational lookahead of a wrap.
// Backpressure: none; priority per edge is clr > load > tick > hold.
// Ports       : clk, rst_n (async active-low), bus (mod_counter_p_if.slave).
module mod_counter_p
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 2,
    parameter int PRESCALE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    mod_counter_p_if.slave      bus
);
    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             tick;
    logic [WIDTH-1:0] load_clamped;
    logic             at_top;
    logic             at_zero;

    // Any clr or load restarts the prescaler so the next step gets a full period.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (bus.en),
        .sync_clr (bus.clr | bus.load),
        .tick     (tick)
    );

    assign load_clamped = WIDTH'(clamp(CLAMP_W'(bus.load_val), CLAMP_W'(bus.modulus)));

    // >= rather than == so a count stranded above a freshly lowered modulus
    // still wraps on the next up step.
    assign at_top  = (count_q >= bus.modulus);
    assign at_zero = (count_q == '0);

    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (bus.clr) begin
            count_d = '0;
        end else if (bus.load) begin
            count_d = load_clamped;
        end else if (tick) begin
            if (bus.dir == DIR_UP) begin
                if (at_top) begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (at_zero) begin
                    count_d = bus.modulus;
                    wrap_d  = 1'b1;
                end else if (count_q > bus.modulus) begin
                    // Out of range going down: snap to the top, not a wrap.
                    count_d = bus.modulus;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
        end
    end

    assign bus.count = count_q;
    assign bus.wrap  = wrap_q;
    // rst_n gates tc so a downstream stage never sees an enable while in reset.
    assign bus.tc    = rst_n & tick & ~bus.clr & ~bus.load &
                       ((bus.dir == DIR_UP) ? at_top : at_zero);
endmodule

// File: tb/tb_mod_counter_p.sv
// Purpose     : self-checking bench for mod_counter_p (three parameter sets).
// Latency     : checks tc before each edge, count/wrap 1ns after it.
// Backpressure: n/a.
module tb_mod_counter_p;
    logic clk;
    logic rst_n;

    int n_cmp;
    int n_err;

    // DUT 0: WIDTH=2 PRESCALE=1, DUT 1: WIDTH=4 PRESCALE=1, DUT 2: WIDTH=4 PRESCALE=3
    int mw[3] = '{2, 4, 4};
    int mp[3] = '{1, 1, 3};

    // Reference state: plain integers, advanced by the counter rules.
    int m_cnt[3];
    int m_ps[3];
    int m_wrap[3];

    mod_counter_p_if #(.WIDTH(2)) if_a ();
    mod_counter_p_if #(.WIDTH(4)) if_b ();
    mod_counter_p_if #(.WIDTH(4)) if_c ();

    mod_counter_p #(.WIDTH(2), .PRESCALE(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    mod_counter_p #(.WIDTH(4), .PRESCALE(1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    mod_counter_p #(.WIDTH(4), .PRESCALE(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic read_out(input int k, output int c, output int t, output int w);
        case (k)
            0:       begin c = int'(if_a.count); t = int'(if_a.tc); w = int'(if_a.wrap); end
            1:       begin c = int'(if_b.count); t = int'(if_b.tc); w = int'(if_b.wrap); end
            default: begin c = int'(if_c.count); t = int'(if_c.tc); w = int'(if_c.wrap); end
        endcase
    endtask

    task automatic drive(input bit e, input bit d, input bit c, input bit l,
                         input int lv, input int md);
        if_a.en = e; if_a.dir = d; if_a.clr = c; if_a.load = l;
        if_a.load_val = 2'(lv); if_a.modulus = 2'(md);
        if_b.en = e; if_b.dir = d; if_b.clr = c; if_b.load = l;
        if_b.load_val = 4'(lv); if_b.modulus = 4'(md);
        if_c.en = e; if_c.dir = d; if_c.clr = c; if_c.load = l;
        if_c.load_val = 4'(lv); if_c.modulus = 4'(md);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = 0; m_ps[k] = 0; m_wrap[k] = 0;
        end
    endtask

    // One clock cycle: apply inputs, check tc, clock, check count and wrap.
    task automatic cyc(input bit e, input bit d, input bit c, input bit l,
                       input int lv, input int md);
        int m, v, oc, ot, ow, etc;
        bit tk;
        int nc[3];
        int np[3];
        int nw[3];
        drive(e, d, c, l, lv, md);
        #1;
        for (int k = 0; k < 3; k++) begin
            m  = md & ((1 << mw[k]) - 1);
            v  = lv & ((1 << mw[k]) - 1);
            tk = e && (m_ps[k] == mp[k] - 1);
            etc = (tk && !c && !l && (d ? (m_cnt[k] >= m) : (m_cnt[k] == 0))) ? 1 : 0;
            read_out(k, oc, ot, ow);
            check($sformatf("tc[%0d]", k), ot, etc);
            nc[k] = m_cnt[k]; np[k] = m_ps[k]; nw[k] = 0;
            if (c) begin
                nc[k] = 0; np[k] = 0;
            end else if (l) begin
                nc[k] = (v < m) ? v : m; np[k] = 0;
            end else begin
                if (e) np[k] = (m_ps[k] + 1) % mp[k];
                if (tk) begin
                    if (d) begin
                        if (m_cnt[k] >= m) begin nc[k] = 0; nw[k] = 1; end
                        else nc[k] = m_cnt[k] + 1;
                    end else if (m_cnt[k] == 0) begin
                        nc[k] = m; nw[k] = 1;
                    end else if (m_cnt[k] > m) begin
                        nc[k] = m;
                    end else begin
                        nc[k] = m_cnt[k] - 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            m_cnt[k] = nc[k]; m_ps[k] = np[k]; m_wrap[k] = nw[k];
            read_out(k, oc, ot, ow);
            check($sformatf("count[%0d]", k), oc, m_cnt[k]);
            check($sformatf("wrap[%0d]", k), ow, m_wrap[k]);
        end
    endtask

    // Reset with inputs that would raise tc if it were not gated by rst_n.
    task automatic do_reset();
        int oc, ot, ow;
        rst_n = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        #12;
        for (int k = 0; k < 3; k++) begin
            read_out(k, oc, ot, ow);
            check($sformatf("rst_count[%0d]", k), oc, 0);
            check($sformatf("rst_wrap[%0d]", k), ow, 0);
            check($sformatf("rst_tc[%0d]", k), ot, 0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    int seq_cnt[7]  = '{1, 2, 0, 1, 2, 0, 1};
    int seq_wrap[7] = '{0, 0, 1, 0, 0, 1, 0};
    int dn_cnt[5]   = '{2, 1, 0, 9, 8};
    int dn_wrap[5]  = '{0, 0, 0, 1, 0};

    initial begin
        int cur_mod, oc, ot, ow;
        n_cmp = 0;
        n_err = 0;
        model_reset();
        do_reset();

        // Mod-3 up sequence on the 2-bit counter.
        for (int i = 0; i < 7; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 2);
            check("t1_count_a", int'(if_a.count), seq_cnt[i]);
            check("t1_wrap_a", int'(if_a.wrap), seq_wrap[i]);
        end

        // Load 3, count down with modulus 9.
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 3, 9);
        check("t2_load_b", int'(if_b.count), 3);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 9);
            check("t2_count_b", int'(if_b.count), dn_cnt[i]);
            check("t2_wrap_b", int'(if_b.wrap), dn_wrap[i]);
        end

        // Prescale by 3, then hold en low mid-period.
        do_reset();
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 15);
        check("t3_count_c", int'(if_c.count), 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 15);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 15);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0, 15);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 15);
        check("t3_hold_c", int'(if_c.count), 3);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 15);
        check("t3_step_c", int'(if_c.count), 4);

        // Modulus lowered below the current count.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 12, 15);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 5);
        check("t4_up_count_b", int'(if_b.count), 0);
        check("t4_up_wrap_b", int'(if_b.wrap), 1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 12, 15);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 5);
        check("t4_dn_count_b", int'(if_b.count), 5);
        check("t4_dn_wrap_b", int'(if_b.wrap), 0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 14, 5);
        check("t4_clamp_b", int'(if_b.count), 5);

        // modulus=0: every tick wraps, wrap stays high.
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
            check("t4_mod0_wrap_b", int'(if_b.wrap), 1);
        end

        // clr beats load and tick.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 7, 15);
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 3, 15);
        check("t5_clr_count_b", int'(if_b.count), 0);
        check("t5_clr_wrap_b", int'(if_b.wrap), 0);

        // Async reset between edges at count 4.
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 4, 15);
        check("t5_pre_b", int'(if_b.count), 4);
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            read_out(k, oc, ot, ow);
            check($sformatf("t5_async_count[%0d]", k), oc, 0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 0, 0);
        #2;
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 15);

        // Randomized traffic against the reference model.
        cur_mod = 9;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 9) == 0) cur_mod = $urandom_range(0, 15);
            cyc($urandom_range(0, 4) != 0,
                1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 19) == 0,
                $urandom_range(0, 15),
                cur_mod);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
